// File: rtl/jk_input_conditioner.sv
// Button front end for jk_ff: synchronises and debounces J/K/S/STEP and turns STEP presses into CE strobes.
// DBG_STATE exposes the four debounce FSM states, two bits per channel, packed as {STEP, S, K, J}.
module jk_input_conditioner #(
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 16,
    parameter int REPEAT_CYCLES = 0,
    parameter int CNT_W         = 8
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             BTN_J,
    input  logic             BTN_K,
    input  logic             BTN_S,
    input  logic             BTN_STEP,
    output logic             J,
    output logic             K,
    output logic             S,
    output logic             CE,
    output logic [CNT_W-1:0] STEP_CNT,
    output logic [7:0]       DBG_STATE
);
    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_WAIT_HI = 2'd1,
        ST_HIGH    = 2'd2,
        ST_WAIT_LO = 2'd3
    } db_state_e;

    localparam int DB_W = $clog2(DB_CYCLES) + 1;
    localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = (REPEAT_CYCLES > 0) ? RP_W'(REPEAT_CYCLES - 1) : '0;

    logic [3:0]      btn;
    logic [3:0]      lvl;
    logic [3:0][1:0] st;

    assign btn = {BTN_STEP, BTN_S, BTN_K, BTN_J};

    for (genvar i = 0; i < 4; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        db_state_e              state_q;
        logic [DB_W-1:0]        cnt_q;
        logic                   lvl_q;
        logic                   s_x;

        assign s_x = sync_q[SYNC_STAGES-1];

        always_ff @(posedge CLK) begin
            if (R) begin
                sync_q  <= '0;
                state_q <= ST_LOW;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn[i]};
                case (state_q)
                    ST_LOW: begin
                        if (s_x) begin
                            state_q <= ST_WAIT_HI;
                            cnt_q   <= '0;
                        end
                    end
                    ST_WAIT_HI: begin
                        if (!s_x) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                            lvl_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!s_x) begin
                            state_q <= ST_WAIT_LO;
                            cnt_q   <= '0;
                        end
                    end
                    ST_WAIT_LO: begin
                        if (s_x) begin
                            state_q <= ST_HIGH;
                            cnt_q   <= '0;
                        end else if (cnt_q == DB_LAST) begin
                            state_q <= ST_LOW;
                            cnt_q   <= '0;
                            lvl_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign lvl[i] = lvl_q;
        assign st[i]  = state_q;
    end

    // The STEP level is 1 exactly while its FSM sits in HIGH or WAIT_LO, which is the repeat window.
    logic            step_enter_hi;
    logic            step_enter_lo;
    logic            ce_d;
    logic            ce_q;
    logic [RP_W-1:0] rep_d;
    logic [RP_W-1:0] rep_q;
    logic [CNT_W-1:0] step_cnt_q;

    assign step_enter_hi = (st[3] == ST_WAIT_HI) && g_ch[3].s_x && (g_ch[3].cnt_q == DB_LAST);
    assign step_enter_lo = (st[3] == ST_WAIT_LO) && !g_ch[3].s_x && (g_ch[3].cnt_q == DB_LAST);

    // CE is a valid-only strobe: one cycle high per event, no ready/backpressure;
    // STEP_CNT already includes the strobe in the same cycle CE is high.
    always_comb begin
        ce_d  = 1'b0;
        rep_d = '0;
        if (step_enter_hi) begin
            ce_d = 1'b1;
        end else if ((REPEAT_CYCLES > 0) && lvl[3] && !step_enter_lo) begin
            if (rep_q == RP_LAST) begin
                ce_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (R) begin
            ce_q       <= 1'b0;
            rep_q      <= '0;
            step_cnt_q <= '0;
        end else begin
            ce_q  <= ce_d;
            rep_q <= rep_d;
            if (ce_d) begin
                step_cnt_q <= step_cnt_q + 1'b1;
            end
        end
    end

    assign J         = lvl[0];
    assign K         = lvl[1];
    assign S         = lvl[2];
    assign CE        = ce_q;
    assign STEP_CNT  = step_cnt_q;
    assign DBG_STATE = st;
endmodule

// File: tb/tb_jk_input_conditioner.sv
// Directed bench for jk_input_conditioner: levels checked inline, CE strobes matched against
// per-instance expected queues of {edge number, STEP_CNT}.
module tb_jk_input_conditioner;
    logic clk = 1'b0;
    logic r;
    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    // default instance
    logic       bj, bk, bs, bst;
    logic       j0, k0, s0, ce0;
    logic [7:0] cnt0, dbg0;
    // auto-repeat instance
    logic       rstep;
    logic       j1, k1, s1, ce1;
    logic [7:0] cnt1, dbg1;
    // narrow counter instance
    logic       cstep;
    logic       j2, k2, s2, ce2;
    logic [1:0] cnt2;
    logic [7:0] dbg2;

    jk_input_conditioner u_dut (
        .CLK(clk), .R(r), .BTN_J(bj), .BTN_K(bk), .BTN_S(bs), .BTN_STEP(bst),
        .J(j0), .K(k0), .S(s0), .CE(ce0), .STEP_CNT(cnt0), .DBG_STATE(dbg0)
    );

    jk_input_conditioner #(.REPEAT_CYCLES(5)) u_rep (
        .CLK(clk), .R(r), .BTN_J(1'b0), .BTN_K(1'b0), .BTN_S(1'b0), .BTN_STEP(rstep),
        .J(j1), .K(k1), .S(s1), .CE(ce1), .STEP_CNT(cnt1), .DBG_STATE(dbg1)
    );

    jk_input_conditioner #(.CNT_W(2)) u_cnt (
        .CLK(clk), .R(r), .BTN_J(1'b0), .BTN_K(1'b0), .BTN_S(1'b0), .BTN_STEP(cstep),
        .J(j2), .K(k2), .S(s2), .CE(ce2), .STEP_CNT(cnt2), .DBG_STATE(dbg2)
    );

    logic [39:0] exp_q0[$];
    logic [39:0] exp_q1[$];
    logic [39:0] exp_q2[$];
    logic [39:0] e0, e1, e2;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_neg(input int k);
        do @(negedge clk); while (edge_n < k);
    endtask

    // Scoreboard monitors: every CE pops one expected {edge, count} entry.
    always @(negedge clk) begin
        if (ce0) begin
            if (exp_q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut_ce: strobe at edge %0d cnt %0d, required none", edge_n, cnt0);
            end else begin
                e0 = exp_q0.pop_front();
                check("dut_ce_edge", edge_n, e0[39:8]);
                check("dut_ce_cnt", cnt0, e0[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (ce1) begin
            if (exp_q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rep_ce: strobe at edge %0d cnt %0d, required none", edge_n, cnt1);
            end else begin
                e1 = exp_q1.pop_front();
                check("rep_ce_edge", edge_n, e1[39:8]);
                check("rep_ce_cnt", cnt1, e1[7:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (ce2) begin
            if (exp_q2.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL cnt_ce: strobe at edge %0d cnt %0d, required none", edge_n, cnt2);
            end else begin
                e2 = exp_q2.pop_front();
                check("cnt_ce_edge", edge_n, e2[39:8]);
                check("cnt_ce_cnt", 32'(cnt2), e2[7:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at edge %0d, required normal end", edge_n);
        $fatal(1, "watchdog");
    end

    int d;

    initial begin
        r = 1'b1; bj = 1'b1; bk = 1'b1; bs = 1'b1; bst = 1'b1; rstep = 1'b0; cstep = 1'b0;

        // Reset held on edges 1..3 with every default-instance button pressed.
        wait_neg(2);
        check("rst_j", j0, 0);
        check("rst_k", k0, 0);
        check("rst_s", s0, 0);
        check("rst_ce", ce0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_dbg", dbg0, 0);
        check("rst_rep_out", {j1, k1, s1, ce1, cnt1, dbg1}, 0);
        check("rst_cnt_out", {j2, k2, s2, ce2, cnt2, dbg2}, 0);
        step(1);
        r = 1'b0; d = edge_n;
        exp_q0.push_back({32'(d + 19), 8'd1});
        wait_neg(d + 18);
        check("pre_j", j0, 0);
        check("pre_k", k0, 0);
        check("pre_s", s0, 0);
        wait_neg(d + 19);
        check("post_j", j0, 1);
        check("post_k", k0, 1);
        check("post_s", s0, 1);
        step(5);
        bj = 1'b0; bk = 1'b0; bs = 1'b0; bst = 1'b0; d = edge_n;
        wait_neg(d + 18);
        check("rel_hold_j", j0, 1);
        check("rel_hold_s", s0, 1);
        wait_neg(d + 19);
        check("rel_j", j0, 0);
        check("rel_k", k0, 0);
        check("rel_s", s0, 0);
        step(5);

        // Short J pulse (10 cycles) is rejected and the FSM settles back in LOW.
        bj = 1'b1;
        step(10);
        bj = 1'b0;
        step(30);
        check("glitch_j", j0, 0);
        check("glitch_j_state", dbg0[1:0], 0);

        // J held 30 cycles: rises 18 edges after first sample, falls 18 after release.
        step(1);
        bj = 1'b1; d = edge_n;
        wait_neg(d + 18);
        check("hold_j_pre", j0, 0);
        wait_neg(d + 19);
        check("hold_j_rise", j0, 1);
        check("hold_k_indep", k0, 0);
        step(11);
        bj = 1'b0; d = edge_n;
        wait_neg(d + 18);
        check("hold_j_still", j0, 1);
        wait_neg(d + 19);
        check("hold_j_fall", j0, 0);

        // STEP bounce 1,0,1,0 at 3-cycle spacing then stable: one strobe (count 2 after the first press).
        step(1);
        bst = 1'b1; step(3); bst = 1'b0; step(3);
        bst = 1'b1; step(3); bst = 1'b0; step(3);
        bst = 1'b1; d = edge_n;
        exp_q0.push_back({32'(d + 19), 8'd2});
        step(40);
        bst = 1'b0;
        step(30);
        check("bounce_cnt", cnt0, 2);

        // Auto-repeat every 5: accept A=d+19, release drives exit to LOW at A+42 -> strobes A+0..A+40.
        step(1);
        rstep = 1'b1; d = edge_n;
        for (int i = 0; i < 9; i++) exp_q1.push_back({32'(d + 19 + 5 * i), 8'(i + 1)});
        step(42);
        rstep = 1'b0;
        step(40);
        check("rep_total", cnt1, 9);
        check("rep_state_low", dbg1[7:6], 0);

        // Two-bit STEP_CNT wraps: 1,2,3,0,1.
        for (int i = 0; i < 5; i++) begin
            step(1);
            cstep = 1'b1; d = edge_n;
            exp_q2.push_back({32'(d + 19), 8'((i + 1) % 4)});
            step(25);
            cstep = 1'b0;
            step(25);
        end
        check("wrap_cnt", 32'(cnt2), 1);

        // Reset pulse while STEP is in WAIT_HI with cnt=10: no strobe, then a full debounce from scratch.
        step(1);
        bst = 1'b1; d = edge_n;
        step(13);
        check("mid_state_wait_hi", dbg0[7:6], 1);
        r = 1'b1;
        step(1);
        r = 1'b0; d = edge_n;
        exp_q0.push_back({32'(d + 19), 8'd1});
        wait_neg(d);
        check("mid_rst_cnt", cnt0, 0);
        check("mid_rst_dbg", dbg0, 0);
        wait_neg(d + 18);
        check("mid_pre_cnt", cnt0, 0);
        wait_neg(d + 19);
        check("mid_post_cnt", cnt0, 1);
        step(10);
        bst = 1'b0;
        step(30);

        check("dut_pending", exp_q0.size(), 0);
        check("rep_pending", exp_q1.size(), 0);
        check("cnt_pending", exp_q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
